// File: rtl/sram_burst_ctrl.sv
// Burst access controller in front of an on-chip SRAM port: read, write and fill bursts with window wrap.
// Latency: first SRAM strobe one cycle after command accept; read data returns RD_LAT+1 cycles after its strobe.
// Backpressure: one command at a time (cmd_ready only in IDLE); write beats stall on wr_valid with address held.
module sram_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 4,
  parameter int RD_LAT = 1,
  parameter int WIN_LO = 0,
  parameter int WIN_HI = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              sram_re,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FILL  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Per-command context: next address to issue, beats left after the one on the bus, fill value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] fill;
  } ctx_t;

  localparam logic [ADDR_W-1:0] LO   = ADDR_W'(WIN_LO);
  localparam logic [ADDR_W-1:0] HI   = ADDR_W'(WIN_HI);
  localparam logic [ADDR_W-1:0] SPAN = HI - LO;

  state_t            state, state_nxt;
  ctx_t              ctx, ctx_nxt;
  logic              re_nxt, we_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              in_win, reject, inflight;

  // pipe[i] tags a read issued i+1 cycles ago; chain prepends the strobe of the current cycle.
  logic [RD_LAT:0]   pipe;
  logic [RD_LAT+1:0] chain;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] cur);
    return (cur == HI) ? LO : cur + ADDR_W'(1);
  endfunction

  // Modular distance from LO avoids a signed/constant-zero lower-bound compare.
  assign in_win    = (cmd_addr - LO) <= SPAN;
  assign reject    = (cmd_op == 2'b11) || !in_win;
  assign chain     = {pipe, sram_re};
  assign inflight  = |chain[RD_LAT:0];
  assign rd_valid  = chain[RD_LAT+1];
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign done      = (state == DONE);

  // Next-state, next-context and next SRAM strobe decode.
  always_comb begin
    state_nxt = state;
    ctx_nxt   = ctx;
    re_nxt    = 1'b0;
    we_nxt    = 1'b0;
    err_nxt   = 1'b0;
    addr_nxt  = sram_addr;
    wdata_nxt = sram_wdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (reject) begin
            err_nxt = 1'b1;
          end else begin
            ctx_nxt.addr = cmd_addr;
            ctx_nxt.cnt  = cmd_len;
            ctx_nxt.fill = cmd_fill;
            case (cmd_op)
              2'b00: begin
                state_nxt    = READ;
                re_nxt       = 1'b1;
                addr_nxt     = cmd_addr;
                ctx_nxt.addr = step_addr(cmd_addr);
              end
              2'b01: state_nxt = WRITE;
              2'b10: begin
                state_nxt    = FILL;
                we_nxt       = 1'b1;
                addr_nxt     = cmd_addr;
                wdata_nxt    = cmd_fill;
                ctx_nxt.addr = step_addr(cmd_addr);
              end
              default: state_nxt = IDLE;
            endcase
          end
        end
      end
      READ: begin
        if (ctx.cnt == '0) begin
          state_nxt = DRAIN;
        end else begin
          re_nxt       = 1'b1;
          addr_nxt     = ctx.addr;
          ctx_nxt.addr = step_addr(ctx.addr);
          ctx_nxt.cnt  = ctx.cnt - LEN_W'(1);
        end
      end
      FILL: begin
        if (ctx.cnt == '0) begin
          state_nxt = DONE;
        end else begin
          we_nxt       = 1'b1;
          addr_nxt     = ctx.addr;
          wdata_nxt    = ctx.fill;
          ctx_nxt.addr = step_addr(ctx.addr);
          ctx_nxt.cnt  = ctx.cnt - LEN_W'(1);
        end
      end
      WRITE: begin
        if (wr_valid) begin
          we_nxt       = 1'b1;
          addr_nxt     = ctx.addr;
          wdata_nxt    = wr_data;
          ctx_nxt.addr = step_addr(ctx.addr);
          // The last beat's strobe goes out while in DRAIN, so done lands one cycle later.
          if (ctx.cnt == '0) state_nxt = DRAIN;
          else               ctx_nxt.cnt = ctx.cnt - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (!inflight) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and command context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctx   <= '0;
    end else begin
      state <= state_nxt;
      ctx   <= ctx_nxt;
    end
  end

  // Registered SRAM port and reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      err        <= 1'b0;
    end else begin
      sram_re    <= re_nxt;
      sram_we    <= we_nxt;
      sram_addr  <= addr_nxt;
      sram_wdata <= wdata_nxt;
      err        <= err_nxt;
    end
  end

  // Read-return tag pipe; data is captured in the cycle the SRAM presents it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe    <= '0;
      rd_data <= '0;
    end else begin
      pipe <= chain[RD_LAT:0];
      if (chain[RD_LAT]) rd_data <= sram_rdata;
    end
  end

endmodule
